// File: rtl/issue_queue.sv
// Issue queue: dispatch into lowest free entry, wakeup via two writeback tag ports,
// clear on arbiter grants. Optional dispatch stall counter enabled by IQ_STALL_CNT_EN.
module issue_queue #(
  parameter int unsigned IQ_DEPTH     = 16,
  parameter int unsigned OPCODE_WIDTH = 7,
  parameter int unsigned AGE_WIDTH    = 5,
  parameter int unsigned PTAG_WIDTH   = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             disp_valid,
  output logic                             disp_ready,
  input  logic [OPCODE_WIDTH-1:0]          disp_op,
  input  logic                             disp_src0_use,
  input  logic                             disp_src1_use,
  input  logic [PTAG_WIDTH-1:0]            disp_src0_tag,
  input  logic [PTAG_WIDTH-1:0]            disp_src1_tag,
  input  logic [PTAG_WIDTH-1:0]            disp_dst_tag,
  input  logic [1:0]                       wb_valid,
  input  logic [2*PTAG_WIDTH-1:0]          wb_tag,
  input  logic [3:0]                       gnt_valid,
  input  logic [15:0]                      gnt_idx,
  output logic [IQ_DEPTH*OPCODE_WIDTH-1:0] op_flat,
  output logic [IQ_DEPTH-1:0]              req,
  output logic [IQ_DEPTH*AGE_WIDTH-1:0]    age_flat,
  output logic [IQ_DEPTH*PTAG_WIDTH-1:0]   dst_flat,
  output logic [4:0]                       count,
  output logic [31:0]                      stall_cnt
);

  localparam int unsigned IDX_W   = $clog2(IQ_DEPTH);
  localparam int unsigned GNT_W   = 4;
  localparam int unsigned N_GNT   = 4;
  localparam int unsigned CNT_W   = 5;

  logic [IQ_DEPTH-1:0]     valid_q;
  logic [IQ_DEPTH-1:0]     rdy0_q;
  logic [IQ_DEPTH-1:0]     rdy1_q;
  logic [OPCODE_WIDTH-1:0] op_q   [IQ_DEPTH];
  logic [PTAG_WIDTH-1:0]   src0_q [IQ_DEPTH];
  logic [PTAG_WIDTH-1:0]   src1_q [IQ_DEPTH];
  logic [PTAG_WIDTH-1:0]   dst_q  [IQ_DEPTH];
  logic [AGE_WIDTH-1:0]    age_q  [IQ_DEPTH];

  logic                    free_any;
  logic [IDX_W-1:0]        alloc_idx;
  logic                    alloc_en;
  logic [IQ_DEPTH-1:0]     gnt_clr;
  logic                    disp_rdy0;
  logic                    disp_rdy1;

  function automatic logic wb_hit(input logic [1:0]              v,
                                  input logic [2*PTAG_WIDTH-1:0] t,
                                  input logic [PTAG_WIDTH-1:0]   tag);
    wb_hit = (v[0] && (t[PTAG_WIDTH-1:0] == tag)) ||
             (v[1] && (t[2*PTAG_WIDTH-1:PTAG_WIDTH] == tag));
  endfunction

  // Lowest-index free entry, looked up in registered state only so grants never collide
  always_comb begin
    free_any  = 1'b0;
    alloc_idx = '0;
    for (int i = int'(IQ_DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_any  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
    end
  end

  assign disp_ready = free_any & ~flush;
  assign alloc_en   = disp_valid & disp_ready;
  assign disp_rdy0  = ~disp_src0_use | wb_hit(wb_valid, wb_tag, disp_src0_tag);
  assign disp_rdy1  = ~disp_src1_use | wb_hit(wb_valid, wb_tag, disp_src1_tag);

  // Grant ports OR into one clear mask, so duplicate grants clear an entry once
  always_comb begin
    gnt_clr = '0;
    for (int n = 0; n < int'(N_GNT); n++) begin
      for (int i = 0; i < int'(IQ_DEPTH); i++) begin
        if (gnt_valid[n] && (gnt_idx[n*GNT_W +: GNT_W] == GNT_W'(i))) begin
          gnt_clr[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rdy0_q  <= '0;
      rdy1_q  <= '0;
      for (int i = 0; i < int'(IQ_DEPTH); i++) begin
        op_q[i]   <= '0;
        src0_q[i] <= '0;
        src1_q[i] <= '0;
        dst_q[i]  <= '0;
        age_q[i]  <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < int'(IQ_DEPTH); i++) begin
        if (alloc_en && (alloc_idx == IDX_W'(i))) begin
          valid_q[i] <= 1'b1;
          op_q[i]    <= disp_op;
          src0_q[i]  <= disp_src0_tag;
          src1_q[i]  <= disp_src1_tag;
          dst_q[i]   <= disp_dst_tag;
          age_q[i]   <= '0;
          rdy0_q[i]  <= disp_rdy0;
          rdy1_q[i]  <= disp_rdy1;
        end else if (valid_q[i]) begin
          if (gnt_clr[i]) begin
            valid_q[i] <= 1'b0;
          end
          if (!rdy0_q[i] && wb_hit(wb_valid, wb_tag, src0_q[i])) begin
            rdy0_q[i] <= 1'b1;
          end
          if (!rdy1_q[i] && wb_hit(wb_valid, wb_tag, src1_q[i])) begin
            rdy1_q[i] <= 1'b1;
          end
          if (age_q[i] != '1) begin
            age_q[i] <= age_q[i] + AGE_WIDTH'(1);
          end
        end
      end
    end
  end

  // Flattened per-entry views for the arbiters
  always_comb begin
    req      = '0;
    op_flat  = '0;
    age_flat = '0;
    dst_flat = '0;
    count    = '0;
    for (int i = 0; i < int'(IQ_DEPTH); i++) begin
      req[i]                                = valid_q[i] & rdy0_q[i] & rdy1_q[i];
      op_flat[i*OPCODE_WIDTH +: OPCODE_WIDTH] = op_q[i];
      age_flat[i*AGE_WIDTH +: AGE_WIDTH]      = age_q[i];
      dst_flat[i*PTAG_WIDTH +: PTAG_WIDTH]    = dst_q[i];
      count                                 = count + CNT_W'(valid_q[i]);
    end
  end

`ifdef IQ_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (disp_valid && !disp_ready) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: dispatch, wakeup/bypass, full/stall, grants, age, flush, reset.
module tb_issue_queue;

  localparam int D  = 16;
  localparam int OW = 7;
  localparam int AW = 5;
  localparam int PW = 6;
`ifdef IQ_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            disp_valid;
  logic            disp_ready;
  logic [OW-1:0]   disp_op;
  logic            disp_src0_use;
  logic            disp_src1_use;
  logic [PW-1:0]   disp_src0_tag;
  logic [PW-1:0]   disp_src1_tag;
  logic [PW-1:0]   disp_dst_tag;
  logic [1:0]      wb_valid;
  logic [2*PW-1:0] wb_tag;
  logic [3:0]      gnt_valid;
  logic [15:0]     gnt_idx;
  logic [D*OW-1:0] op_flat;
  logic [D-1:0]    req;
  logic [D*AW-1:0] age_flat;
  logic [D*PW-1:0] dst_flat;
  logic [4:0]      count;
  logic [31:0]     stall_cnt;

  int n_cmp;
  int n_err;
  int stall_seen;

  issue_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_src0_use(disp_src0_use), .disp_src1_use(disp_src1_use),
    .disp_src0_tag(disp_src0_tag), .disp_src1_tag(disp_src1_tag),
    .disp_dst_tag(disp_dst_tag), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .op_flat(op_flat), .req(req),
    .age_flat(age_flat), .dst_flat(dst_flat), .count(count), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] op_at(input int i);
    op_at = 64'(op_flat[i*OW +: OW]);
  endfunction

  function automatic logic [63:0] age_at(input int i);
    age_at = 64'(age_flat[i*AW +: AW]);
  endfunction

  function automatic logic [63:0] dst_at(input int i);
    dst_at = 64'(dst_flat[i*PW +: PW]);
  endfunction

  function automatic logic [63:0] stall_exp();
    stall_exp = STALL_EN ? 64'(stall_seen) : 64'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; disp_valid = 1'b0; disp_op = '0;
    disp_src0_use = 1'b0; disp_src1_use = 1'b0;
    disp_src0_tag = '0; disp_src1_tag = '0; disp_dst_tag = '0;
    wb_valid = '0; wb_tag = '0; gnt_valid = '0; gnt_idx = '0;
  endtask

  task automatic disp(input logic [OW-1:0] op, input logic u0, input logic [PW-1:0] t0,
                      input logic u1, input logic [PW-1:0] t1, input logic [PW-1:0] dst);
    disp_op = op; disp_src0_use = u0; disp_src0_tag = t0;
    disp_src1_use = u1; disp_src1_tag = t1; disp_dst_tag = dst;
    disp_valid = 1'b1;
    tick();
    disp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    n_cmp = 0; n_err = 0; stall_seen = 0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_req", 64'(req), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    check("rst_op0", op_at(0), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 64'(disp_ready), 64'd1);

    // Basic dispatch, both sources unused
    disp(7'h33, 1'b0, 6'd0, 1'b0, 6'd0, 6'd9);
    check("d0_req", 64'(req), 64'h1);
    check("d0_count", 64'(count), 64'd1);
    check("d0_op", op_at(0), 64'h33);
    check("d0_dst", dst_at(0), 64'd9);
    check("d0_age0", age_at(0), 64'd0);
    tick();
    check("d0_age1", age_at(0), 64'd1);
    gnt_valid = 4'b0001; gnt_idx = 16'h0000;
    tick();
    gnt_valid = '0;
    check("g0_count", 64'(count), 64'd0);
    check("g0_req", 64'(req), 64'd0);

    // Wakeup two cycles after dispatch
    disp(7'h13, 1'b1, 6'd5, 1'b0, 6'd0, 6'd1);
    check("wk_req_d", 64'(req), 64'd0);
    tick();
    check("wk_req_d1", 64'(req), 64'd0);
    wb_valid = 2'b01; wb_tag = {6'd0, 6'd5};
    #1;
    check("wk_req_same", 64'(req), 64'd0);
    tick();
    wb_valid = '0;
    check("wk_req_after", 64'(req), 64'h1);

    // Bypass: wakeup on port 1 in the dispatch cycle readies both sources
    wb_valid = 2'b10; wb_tag = {6'd5, 6'd0};
    disp(7'h13, 1'b1, 6'd5, 1'b1, 6'd5, 6'd2);
    wb_valid = '0;
    check("byp_req", 64'(req), 64'h3);

    // Wrong tag on valid port and matching tag on invalid port do not wake
    wb_valid = 2'b01; wb_tag = {6'd12, 6'd13};
    disp(7'h23, 1'b0, 6'd0, 1'b1, 6'd12, 6'd3);
    wb_valid = '0;
    check("nowake_req", 64'(req), 64'h3);
    wb_valid = 2'b10; wb_tag = {6'd12, 6'd0};
    tick();
    wb_valid = '0;
    check("wake_p1_req", 64'(req), 64'h7);
    gnt_valid = 4'b0111; gnt_idx = {4'd0, 4'd2, 4'd1, 4'd0};
    tick();
    gnt_valid = '0;
    check("clr3_count", 64'(count), 64'd0);

    // Fill all 16 entries
    for (int i = 0; i < D; i++) begin
      disp(7'(i), 1'b0, 6'd0, 1'b0, 6'd0, 6'(i));
    end
    check("full_count", 64'(count), 64'd16);
    check("full_ready", 64'(disp_ready), 64'd0);
    check("full_req", 64'(req), 64'hFFFF);
    check("full_op15", op_at(15), 64'd15);
    check("full_dst10", dst_at(10), 64'd10);

    // Stall while full
    disp_valid = 1'b1; disp_op = 7'h7F;
    repeat (3) begin
      tick();
      stall_seen++;
    end
    check("stall_cnt3", 64'(stall_cnt), stall_exp());
    check("stall_op0", op_at(0), 64'd0);

    // Grant entry 7 while still dispatching; freed slot is not reused this cycle
    disp_op = 7'h55; disp_dst_tag = 6'h2A;
    gnt_valid = 4'b0100; gnt_idx = {4'd0, 4'd7, 4'd0, 4'd0};
    #1;
    check("g7_ready_same", 64'(disp_ready), 64'd0);
    tick();
    stall_seen++;
    gnt_valid = '0; disp_valid = 1'b0;
    check("g7_count", 64'(count), 64'd15);
    check("g7_op_kept", op_at(7), 64'd7);
    check("g7_ready", 64'(disp_ready), 64'd1);
    check("g7_req", 64'(req), 64'hFF7F);
    check("g7_stall", 64'(stall_cnt), stall_exp());
    disp(7'h55, 1'b0, 6'd0, 1'b0, 6'd0, 6'h2A);
    check("re7_op", op_at(7), 64'h55);
    check("re7_dst", dst_at(7), 64'h2A);
    check("re7_age", age_at(7), 64'd0);
    check("re7_count", 64'(count), 64'd16);

    // Duplicate grant, grant to empty entry, two distinct grants
    gnt_valid = 4'b0011; gnt_idx = {8'd0, 4'd3, 4'd3};
    tick();
    check("dup_count", 64'(count), 64'd15);
    check("dup_req", 64'(req), 64'hFFF7);
    gnt_valid = 4'b1000; gnt_idx = {4'd9, 12'd0};
    tick();
    check("g9_count", 64'(count), 64'd14);
    tick();
    gnt_valid = '0;
    check("g9_again_count", 64'(count), 64'd14);
    check("g9_req", 64'(req), 64'hFDF7);
    gnt_valid = 4'b0101; gnt_idx = {4'd0, 4'd1, 4'd0, 4'd0};
    tick();
    gnt_valid = '0;
    check("g01_count", 64'(count), 64'd12);
    check("g01_req", 64'(req), 64'hFDF4);

    // Flush drops a concurrent dispatch
    flush = 1'b1; disp_valid = 1'b1; disp_op = 7'h11;
    #1;
    check("fl_ready", 64'(disp_ready), 64'd0);
    tick();
    stall_seen++;
    flush = 1'b0; disp_valid = 1'b0;
    check("fl_count", 64'(count), 64'd0);
    check("fl_req", 64'(req), 64'd0);
    check("fl_op0", op_at(0), 64'd0);
    check("fl_stall", 64'(stall_cnt), stall_exp());

    // Age saturation on an entry that never becomes ready
    disp(7'h21, 1'b1, 6'd7, 1'b0, 6'd0, 6'd4);
    check("age_op0", op_at(0), 64'h21);
    check("age_req", 64'(req), 64'd0);
    repeat (30) tick();
    check("age30", age_at(0), 64'd30);
    repeat (10) tick();
    check("age_sat", age_at(0), 64'd31);

    // Asynchronous reset mid-operation
    disp(7'h31, 1'b0, 6'd0, 1'b0, 6'd0, 6'd8);
    check("pre_rst_count", 64'(count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_op1", op_at(1), 64'd0);
    check("arst_age0", age_at(0), 64'd0);
    check("arst_stall", 64'(stall_cnt), 64'd0);
    stall_seen = 0;
    tick();
    rst_n = 1'b1;
    tick();
    disp(7'h44, 1'b0, 6'd0, 1'b0, 6'd0, 6'd1);
    check("post_rst_op0", op_at(0), 64'h44);
    check("post_rst_req", 64'(req), 64'h1);
    check("post_rst_count", 64'(count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameters: IQ_DEPTH, 16, number of entries; OPCODE_WIDTH, 7, opcode bits; AGE_WIDTH, 5, age bits; PTAG_WIDTH, 6, physical tag bits.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  clear all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept
- disp_op  in  OPCODE_WIDTH  opcode
- disp_src0_use / disp_src1_use  in  1 each  source operand present
- disp_src0_tag / disp_src1_tag  in  PTAG_WIDTH each  source physical tag
- disp_dst_tag  in  PTAG_WIDTH  destination tag
- wb_valid  in  2  wakeup broadcast valid, ports 0/1
- wb_tag  in  2*PTAG_WIDTH  wakeup tags, port n at [n*PTAG_WIDTH +: PTAG_WIDTH]
- gnt_valid  in  4  grants from ALU0, ALU1, MUL, LS arbiters
- gnt_idx  in  16  granted entry index, port n at [4n +: 4]
- op_flat  out  IQ_DEPTH*OPCODE_WIDTH  per-entry opcode to arbiters
- req  out  IQ_DEPTH  per-entry issue request
- age_flat  out  IQ_DEPTH*AGE_WIDTH  per-entry age to arbiters
- dst_flat  out  IQ_DEPTH*PTAG_WIDTH  per-entry destination tag
- count  out  5  occupied entries
- stall_cnt  out  32  dispatch stall cycles

Function
REQ-003 Entry state SHALL be registered: valid, op, src0/src1 tag, src0/src1 ready, dst tag, age.
REQ-004 req[i] SHALL be combinational: valid[i] & src0_rdy[i] & src1_rdy[i].
REQ-005 disp_ready SHALL be 1 when at least one registered valid bit is 0 and flush is 0; entries freed by a grant in the same cycle are not reusable until the next cycle.
REQ-006 On disp_valid & disp_ready, the lowest-index free entry SHALL be written at the clock edge, age set to 0.
REQ-007 A source with use=0 SHALL be written ready=1; with use=1 it SHALL be written ready=1 if its tag equals any valid wb_tag in the same cycle (bypass), else ready=0.
REQ-008 For every valid entry, a not-ready source SHALL become ready at the edge when any valid wb_tag equals its tag; ready never returns to 0 while the entry is valid.
REQ-009 Age of every valid entry SHALL increment by 1 per cycle, saturating at 2^AGE_WIDTH-1 (31).
REQ-010 gnt_valid[n] SHALL clear valid of entry gnt_idx[n] at the edge; grant to an already-invalid entry SHALL be ignored; two ports granting the same index SHALL clear it once.
REQ-011 Allocation and grant SHALL not collide: allocation uses only entries free in registered state.
REQ-012 count SHALL equal the popcount of registered valid bits (0..16).
REQ-013 flush SHALL clear all valid bits at the edge and take priority over allocation, grant and wakeup; disp_ready SHALL be 0 while flush=1.
REQ-014 Outputs for invalid entries SHALL hold last written values; consumers qualify with req.

Reset
REQ-015 rst_n low SHALL asynchronously clear all valid, ready and age bits, count=0, stall_cnt=0, disp_ready=1 after release; op/tag fields SHALL reset to 0.
REQ-016 Reset mid-operation SHALL discard all entries; first dispatch after release goes to entry 0.

Configuration
REQ-017 Macro IQ_STALL_CNT_EN: defined -> stall_cnt increments (wrapping at 2^32) each cycle disp_valid=1 & disp_ready=0; undefined -> stall_cnt tied to 0, no counter register.

Verification
REQ-018 Reset, dispatch op=0x33 both use=0 -> next cycle entry 0 valid, req[0]=1, count=1, age 0 then 1.
REQ-019 Dispatch src0_tag=5 use=1, wb tag 5 two cycles later -> req[0]=0 until the edge after wakeup, then 1; repeat with wb tag 5 in dispatch cycle -> req[0]=1 immediately.
REQ-020 16 dispatches -> count=16, disp_ready=0, stall_cnt increments per stalled cycle (macro on); grant entry 7 -> next cycle disp_ready=1, next dispatch lands in entry 7.
REQ-021 gnt_valid=4'b0011 both gnt_idx=3 -> entry 3 cleared, count drops by exactly 1; grant to empty entry 9 -> no change.
REQ-022 Hold entry 40 cycles unissued -> age saturates at 31; flush with disp_valid=1 -> all req=0, count=0, dispatch dropped.
